// File: rtl/inst_issue_queue.sv
// Host instruction FIFO with an in-order issue FSM. Each instruction is held until its
// target resource is idle. SYNC drains all resources before later instructions may issue.
module inst_issue_queue #(
   parameter  int DEPTH = 8,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      h2f_io,
   input  logic             h2f_write,
   input  logic             clr_ovf,
   input  logic             mover_busy,
   input  logic             ldst_busy,
   input  logic             eu_busy,
   output logic [31:0]      issue_inst,
   output logic             issue_valid,
   output logic [CNT_W-1:0] q_count,
   output logic             q_full,
   output logic             ovf,
   output logic             isrunning
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_LOAD  = 3'd1,
      OP_STORE = 3'd2,
      OP_MOVE  = 3'd3,
      OP_FETCH = 3'd4,
      OP_EXEC  = 3'd5,
      OP_SYNC  = 3'd6,
      OP_RSV   = 3'd7
   } opcode_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_GUARD = 2'd2,
      S_DRAIN = 2'd3
   } state_e;

   logic [31:0]      mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   state_e           state_q, state_d;
   logic             issue_valid_q, issue_valid_d;
   logic [31:0]      issue_inst_q, issue_inst_d;

   logic [31:0] head;
   opcode_e     head_op;
   logic        empty, full, push, pop, res_busy, any_busy;

   assign head     = mem_q[rd_ptr_q];
   assign head_op  = opcode_e'(head[31:29]);
   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_W'(DEPTH));
   assign push     = h2f_write && !full;
   assign any_busy = mover_busy || ldst_busy || eu_busy;

   always_comb begin
      res_busy = 1'b0;
      case (head_op)
         OP_LOAD, OP_STORE: res_busy = ldst_busy;
         OP_MOVE:           res_busy = mover_busy;
         OP_FETCH, OP_EXEC: res_busy = eu_busy;
         default:           res_busy = 1'b0;
      endcase
   end

   // One decision per cycle; the head is only popped by IDLE (NOP/reserved/SYNC) or ISSUE.
   always_comb begin
      state_d       = state_q;
      pop           = 1'b0;
      issue_valid_d = 1'b0;
      issue_inst_d  = '0;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               case (head_op)
                  OP_NOP, OP_RSV: pop = 1'b1;
                  OP_SYNC: begin
                     pop     = 1'b1;
                     state_d = S_DRAIN;
                  end
                  default: if (!res_busy) state_d = S_ISSUE;
               endcase
            end
         end
         S_ISSUE: begin
            issue_valid_d = 1'b1;
            issue_inst_d  = head;
            pop           = 1'b1;
            state_d       = S_GUARD;
         end
         S_GUARD: state_d = S_IDLE;
         S_DRAIN: if (!any_busy) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      ovf_d   = ovf_q;
      if (h2f_write && full) ovf_d = 1'b1;
      else if (clr_ovf)      ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= h2f_io;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         ovf_q         <= 1'b0;
         state_q       <= S_IDLE;
         issue_valid_q <= 1'b0;
         issue_inst_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q       <= count_d;
         ovf_q         <= ovf_d;
         state_q       <= state_d;
         issue_valid_q <= issue_valid_d;
         issue_inst_q  <= issue_inst_d;
      end
   end

   assign issue_inst  = issue_inst_q;
   assign issue_valid = issue_valid_q;
   assign q_count     = count_q;
   assign q_full      = full;
   assign ovf         = ovf_q;
   assign isrunning   = !empty || (state_q != S_IDLE) || any_busy;

endmodule

// File: tb/tb_inst_issue_queue.sv
// Self-checking bench for inst_issue_queue: opcode vector table, scoreboarded issue monitor,
// and hand-written sequences for blocking, overflow, SYNC drain and mid-operation reset.
module tb_inst_issue_queue;

   localparam int DEPTH = 8;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [31:0]      h2f_io;
   logic             h2f_write, clr_ovf, mover_busy, ldst_busy, eu_busy;
   logic [31:0]      issue_inst;
   logic             issue_valid;
   logic [CNT_W-1:0] q_count;
   logic             q_full, ovf, isrunning;

   inst_issue_queue #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .h2f_io     (h2f_io),
      .h2f_write  (h2f_write),
      .clr_ovf    (clr_ovf),
      .mover_busy (mover_busy),
      .ldst_busy  (ldst_busy),
      .eu_busy    (eu_busy),
      .issue_inst (issue_inst),
      .issue_valid(issue_valid),
      .q_count    (q_count),
      .q_full     (q_full),
      .ovf        (ovf),
      .isrunning  (isrunning)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   int          issue_cnt = 0;
   int          issue_cyc [$];
   logic [31:0] sb [$];

   always @(posedge clk) cyc <= cyc + 1;

   // Every issue pulse must match the oldest outstanding expected word.
   always @(negedge clk) begin
      if (issue_valid) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_issue got %h want none", issue_inst);
         end else begin
            logic [31:0] exp_w;
            exp_w = sb.pop_front();
            if (issue_inst !== exp_w) begin
               errors++;
               $display("FAIL issue_word got %h want %h", issue_inst, exp_w);
            end
         end
         issue_cnt++;
         issue_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Drives one word for a single cycle; returns at the negedge after it was sampled.
   task automatic write_word(input logic [31:0] w);
      h2f_io    = w;
      h2f_write = 1'b1;
      @(negedge clk);
      h2f_write = 1'b0;
      h2f_io    = '0;
   endtask

   task automatic wait_issues(input string name, input int target, input int budget);
      int n;
      n = 0;
      while (issue_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (issue_cnt < target) begin
         errors++;
         $display("FAIL %s_timeout got %0d issues want %0d", name, issue_cnt, target);
      end
   endtask

   typedef struct {
      logic [31:0] word;
      bit          exp_issue;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int n0, c0;

      vecs[0] = '{32'h0000_0001, 1'b0};  // NOP
      vecs[1] = '{32'h2000_0010, 1'b1};  // LOAD
      vecs[2] = '{32'h4000_0020, 1'b1};  // STORE
      vecs[3] = '{32'h6000_0030, 1'b1};  // MOVE
      vecs[4] = '{32'h8000_0040, 1'b1};  // FETCH
      vecs[5] = '{32'hA000_0050, 1'b1};  // EXEC
      vecs[6] = '{32'hC000_0060, 1'b0};  // SYNC
      vecs[7] = '{32'hE000_0070, 1'b0};  // reserved

      rst_n = 1'b0; h2f_io = '0; h2f_write = 1'b0; clr_ovf = 1'b0;
      mover_busy = 1'b0; ldst_busy = 1'b0; eu_busy = 1'b0;
      cycles(3);
      chk("rst_q_count",     32'(q_count),     32'd0);
      chk("rst_q_full",      32'(q_full),      32'd0);
      chk("rst_ovf",         32'(ovf),         32'd0);
      chk("rst_issue_valid", 32'(issue_valid), 32'd0);
      chk("rst_issue_inst",  issue_inst,       32'd0);
      chk("rst_isrunning",   32'(isrunning),   32'd0);
      rst_n = 1'b1;
      cycles(2);

      // Minimum latency: issue pulse in the cycle after the second edge following the write.
      sb.push_back(32'h2000_0010);
      h2f_io = 32'h2000_0010; h2f_write = 1'b1;
      @(negedge clk);
      h2f_write = 1'b0; h2f_io = '0;
      chk("t1_count_after_write", 32'(q_count), 32'd1);
      chk("t1_valid_e0", 32'(issue_valid), 32'd0);
      @(negedge clk);
      chk("t1_valid_e1", 32'(issue_valid), 32'd0);
      @(negedge clk);
      chk("t1_valid_e2", 32'(issue_valid), 32'd1);
      chk("t1_inst_e2",  issue_inst,       32'h2000_0010);
      chk("t1_count_e2", 32'(q_count),     32'd0);
      @(negedge clk);
      chk("t1_valid_e3", 32'(issue_valid), 32'd0);
      chk("t1_inst_e3",  issue_inst,       32'd0);
      cycles(2);

      // Opcode table, one word at a time with all resources idle.
      for (int i = 0; i < 8; i++) begin
         n0 = issue_cnt;
         if (vecs[i].exp_issue) sb.push_back(vecs[i].word);
         write_word(vecs[i].word);
         cycles(6);
         chk($sformatf("vec%0d_issues", i), 32'(issue_cnt - n0), 32'(vecs[i].exp_issue));
         chk($sformatf("vec%0d_count", i),  32'(q_count),        32'd0);
         chk($sformatf("vec%0d_running", i), 32'(isrunning),     32'd0);
      end

      // Blocked MOVE holds back a LOAD whose resource is idle.
      mover_busy = 1'b1;
      n0 = issue_cnt;
      sb.push_back(32'h6000_0001);
      sb.push_back(32'h2000_0002);
      write_word(32'h6000_0001);
      write_word(32'h2000_0002);
      cycles(5);
      chk("t2_blocked_issues", 32'(issue_cnt - n0), 32'd0);
      chk("t2_blocked_count",  32'(q_count),        32'd2);
      chk("t2_running",        32'(isrunning),      32'd1);
      mover_busy = 1'b0;
      c0 = cyc;
      wait_issues("t2", n0 + 2, 20);
      if (issue_cnt >= n0 + 2) begin
         chk("t2_move_latency", 32'(issue_cyc[n0] - c0),            32'd2);
         chk("t2_load_spacing", 32'(issue_cyc[n0+1] - issue_cyc[n0]), 32'd3);
      end
      cycles(3);

      // Overflow: DEPTH+1 writes while the head is blocked.
      mover_busy = 1'b1;
      n0 = issue_cnt;
      for (int i = 0; i <= DEPTH; i++) begin
         if (i < DEPTH) sb.push_back(32'h6000_0100 + 32'(i));
         h2f_io = 32'h6000_0100 + 32'(i); h2f_write = 1'b1;
         @(negedge clk);
      end
      h2f_write = 1'b0;
      chk("t3_count_full", 32'(q_count), 32'(DEPTH));
      chk("t3_q_full",     32'(q_full),  32'd1);
      chk("t3_ovf_set",    32'(ovf),     32'd1);
      clr_ovf = 1'b1; h2f_write = 1'b1; h2f_io = 32'h6000_01FF;
      @(negedge clk);
      h2f_write = 1'b0;
      chk("t3_set_wins", 32'(ovf), 32'd1);
      @(negedge clk);
      clr_ovf = 1'b0;
      chk("t3_ovf_clear", 32'(ovf), 32'd0);
      chk("t3_no_issue",  32'(issue_cnt - n0), 32'd0);
      mover_busy = 1'b0;
      wait_issues("t3", n0 + DEPTH, 80);
      cycles(4);
      chk("t3_drained_count", 32'(issue_cnt - n0), 32'(DEPTH));
      chk("t3_q_full_after",  32'(q_full),         32'd0);

      // SYNC barrier waits for eu_busy, then releases the STORE.
      n0 = issue_cnt;
      sb.push_back(32'hA000_0005);
      sb.push_back(32'h4000_0006);
      write_word(32'hA000_0005);
      write_word(32'hC000_0000);
      write_word(32'h4000_0006);
      wait_issues("t4_exec", n0 + 1, 10);
      eu_busy = 1'b1;
      cycles(10);
      chk("t4_held_issues", 32'(issue_cnt - n0), 32'd1);
      chk("t4_running",     32'(isrunning),      32'd1);
      chk("t4_held_count",  32'(q_count),        32'd1);
      eu_busy = 1'b0;
      c0 = cyc;
      wait_issues("t4_store", n0 + 2, 10);
      if (issue_cnt >= n0 + 2)
         chk("t4_store_latency", 32'(issue_cyc[n0+1] - c0), 32'd3);
      cycles(3);

      // NOP and reserved back to back: popped silently.
      n0 = issue_cnt;
      write_word(32'h0000_0ABC);
      write_word(32'hFFFF_FFFF);
      cycles(5);
      chk("t5_issues",  32'(issue_cnt - n0), 32'd0);
      chk("t5_count",   32'(q_count),        32'd0);
      chk("t5_running", 32'(isrunning),      32'd0);

      // Reset while draining with three entries queued.
      n0 = issue_cnt;
      eu_busy = 1'b1;
      write_word(32'hC000_0000);
      write_word(32'h6000_0A01);
      write_word(32'h6000_0A02);
      write_word(32'h6000_0A03);
      cycles(3);
      chk("t6_count_pre", 32'(q_count), 32'd3);
      rst_n = 1'b0;
      #1;
      chk("t6_count_in_reset", 32'(q_count), 32'd0);
      @(negedge clk);
      eu_busy = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cycles(8);
      chk("t6_issues",  32'(issue_cnt - n0), 32'd0);
      chk("t6_count",   32'(q_count),        32'd0);
      chk("t6_running", 32'(isrunning),      32'd0);
      chk("sb_empty",   32'(sb.size()),      32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1);
   end

endmodule
